instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, 15, number of cycles without imem_ack in REQ before a fault is declared (range 1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetN  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory read-data valid for the current request.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 instr_valid  output  1  fetched instruction available to decode.
REQ-010 instr_ready  input  1  decode/control accepts the instruction.
REQ-011 instr  output  32  held instruction word.
REQ-012 opCode  output  6  instr[31:26], fed to the main control decoder.
REQ-013 pc_out  output  32  address of the held instruction.
REQ-014 pc_plus4  output  32  pc_out+4, modulo 2^32.
REQ-015 branch_taken  input  1  redirect request, qualified by instr_valid & instr_ready.
REQ-016 branch_target  input  32  redirect address.
REQ-017 fetch_fault  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states IDLE, REQ, HOLD, FAULT; all state and outputs registered.
REQ-019 IDLE: imem_req=0, instr_valid=0; unconditional transition to REQ next cycle.
REQ-020 REQ: imem_req=1, imem_addr=pc; imem_addr stable until the ack cycle.
REQ-021 REQ with imem_ack=1: instr<=imem_rdata, pc_out<=pc, pc<=pc+4 (0xFFFF_FFFC wraps to 0x0000_0000), wait counter cleared, next state HOLD.
REQ-022 REQ with imem_ack=0: wait counter +1; on reaching MAX_WAIT, next state FAULT.
REQ-023 HOLD: imem_req=0, instr_valid=1; instr, opCode, pc_out, pc_plus4 stable until the handshake.
REQ-024 Handshake: instr_valid=1 and instr_ready=1 in the same cycle; next state REQ, instr_valid=0 next cycle.
REQ-025 branch_taken=1 at handshake: pc<={branch_target[31:2],2'b00}; otherwise pc keeps the incremented value.
REQ-026 branch_taken while instr_valid=0, or without instr_ready, is ignored.
REQ-027 imem_ack outside REQ (IDLE, HOLD, FAULT) is ignored; no state, data, or pc change.
REQ-028 FAULT: imem_req=0, instr_valid=0, fetch_fault=1; exit only by reset.
REQ-029 Throughput: with imem_ack asserted in the first REQ cycle and instr_ready held high, one instruction every 2 cycles.
REQ-030 Latency: first instr_valid=1 no earlier than cycle 3 after resetN deasserts (IDLE, REQ, HOLD).

Reset
REQ-031 resetN=0 at a clock edge: state IDLE, pc=RESET_PC, wait counter=0.
REQ-032 During reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opCode=0, pc_out=0, pc_plus4=4, fetch_fault=0.
REQ-033 Reset in REQ or HOLD abandons the outstanding fetch or held instruction; an ack arriving after reset is ignored per REQ-027.
REQ-034 resetN has priority over every other input in the same cycle.

Verification
REQ-035 Reset release, memory acks the first REQ cycle with 0x8C01_0004, ready=1 -> imem_addr=0x0, instr_valid=1 with opCode=6'b100011, pc_out=0, pc_plus4=4; next fetch at 0x4.
REQ-036 ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, instr/pc_out unchanged, imem_req=0; ready=1 -> next imem_addr=pc_out+4.
REQ-037 beq instruction 0x1022_0003 at pc 0x10, branch_taken=1, target 0x0000_0023 at handshake -> next imem_addr=0x20; branch_taken asserted in a non-handshake cycle has no effect.
REQ-038 imem_ack withheld for MAX_WAIT cycles -> fetch_fault=1, imem_req=0, instr_valid=0 and held until resetN=0.
REQ-039 RESET_PC=0xFFFF_FFFC, first fetch acked -> pc_out=0xFFFF_FFFC, pc_plus4=0x0, next imem_addr=0x0.
REQ-040 resetN=0 while in REQ, then a stray imem_ack in IDLE -> instr_valid=0, then a fresh fetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory read at a time. The fetched word is held
// until decode accepts it, and a memory that never acks latches a sticky fault.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StFault
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [7:0]  wait_q, wait_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        wait_d     = wait_q;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_out_d   = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    pc_d       = pc_q + 32'd4;
                    wait_d     = 8'd0;
                    state_d    = StHold;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    state_d = StReq;
                    // pc already holds the sequential successor; only a redirect overrides it
                    if (branch_taken) begin
                        pc_d = {branch_target[31:2], 2'b00};
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

        // Output flags are decoded from the next state so they leave a flop directly
        req_d   = (state_d == StReq);
        valid_d = (state_d == StHold);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_out_q   <= 32'd0;
            pc_plus4_q <= 32'd4;
            wait_q     <= 8'd0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opCode      = instr_q[31:26];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program-order model predicts every fetch address and presented
// instruction; a negedge monitor compares them against a scoreboard queue.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFFC;
    localparam int unsigned MAX_WAIT  = 15;

    logic        clk;
    logic        resetN;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, instr, pc_out, pc_plus4;
    logic [5:0]  opCode;

    logic        imem_req2, instr_valid2, fetch_fault2;
    logic [31:0] imem_addr2, instr2, pc_out2, pc_plus42;
    logic [5:0]  opCode2;

    instr_fetch #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetN(resetN), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opCode(opCode), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .branch_taken(branch_taken), .branch_target(branch_target),
        .fetch_fault(fetch_fault)
    );

    // Shares all inputs with dut; used only to check the top-of-address-space wrap
    instr_fetch #(.RESET_PC(RESET_PC2), .MAX_WAIT(MAX_WAIT)) dut2 (
        .clk(clk), .resetN(resetN), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid2),
        .instr_ready(instr_ready), .instr(instr2), .opCode(opCode2), .pc_out(pc_out2),
        .pc_plus4(pc_plus42), .branch_taken(branch_taken), .branch_target(branch_target),
        .fetch_fault(fetch_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pres = 0;
    int          valid_seen = 0;
    bit          mon_en = 0;
    bit          prev_valid = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1022_0003;
        return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem(pc);
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus; the model advances program order on every accepted instruction
    task automatic drive(input bit ack, input bit rdy, input bit br, input logic [31:0] tgt);
        if (instr_valid) valid_seen++;
        imem_ack      = ack;
        imem_rdata    = (ack && imem_req) ? mem(imem_addr) : $urandom;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        if (instr_valid && rdy) begin
            model_pc = br ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
            push_exp(model_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en        = 0;
        resetN        = 1'b0;
        imem_ack      = 1'b1;
        imem_rdata    = $urandom;
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = $urandom;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opCode, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_addr2", imem_addr2, RESET_PC2);
        exp_q.delete();
        model_pc = RESET_PC;
        push_exp(RESET_PC);
        resetN       = 1'b1;
        imem_ack     = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        mon_en       = 1;
    endtask

    // IDLE cycle with stray ack/ready/branch, then the first request must come from RESET_PC
    task automatic post_reset();
        drive(1, 1, 1, $urandom);
        chk("idle_to_req", imem_req, 1);
        chk("idle_valid", instr_valid, 0);
        chk("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic to_hold();
        int n = 0;
        while (!instr_valid && n < 20) begin
            drive(imem_req, 0, 1, $urandom);
            n++;
        end
        chk("reached_hold", instr_valid, 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid && !prev_valid) begin
                n_pres++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h expected none", pc_out);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (instr_valid) begin
                chk("instr", instr, cur.word);
                chk("pc_out", pc_out, cur.pc);
                chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
                chk("opcode", {26'd0, opCode}, {26'd0, cur.word[31:26]});
                chk("req_in_hold", imem_req, 0);
            end
            if (imem_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
                end else begin
                    chk("imem_addr", imem_addr, exp_q[0].pc);
                end
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  nack;
        int  n;
        bit  a;

        resetN        = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        model_pc      = RESET_PC;

        do_reset();
        post_reset();
        // First fetch acked immediately: valid on the third cycle after reset release
        drive(1, 0, 0, 32'd0);
        chk("latency_valid", instr_valid, 1);
        chk("first_opcode", {26'd0, opCode}, 32'h23);
        chk("wrap_pc_out", pc_out2, RESET_PC2);
        chk("wrap_pc_plus4", pc_plus42, 32'd0);
        drive(0, 1, 0, 32'd0);
        chk("wrap_next_addr", imem_addr2, 32'd0);
        chk("next_addr", imem_addr, 32'd4);

        // Walk to the beq at 0x10 with stalls and branch noise outside the handshake
        repeat (4) begin
            to_hold();
            repeat (5) drive(1, 0, 1, $urandom);
            chk("stall_valid", instr_valid, 1);
            chk("stall_req", imem_req, 0);
            if (pc_out == 32'h10) drive(0, 1, 1, 32'h0000_0023);
            else drive(0, 1, 0, $urandom);
        end
        chk("branch_addr", imem_addr, 32'h20);

        valid_seen = 0;
        repeat (20) drive(imem_req, 1, 0, 32'd0);
        chk("throughput", valid_seen, 10);

        nack = 0;
        repeat (3000) begin
            if (imem_req) begin
                a    = (nack >= 4) || ($urandom_range(0, 2) != 0);
                nack = a ? 0 : nack + 1;
            end else begin
                a = ($urandom_range(0, 3) == 0);
            end
            drive(a, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom);
        end
        chk("presentations", n_pres > 300, 1);

        // Reset while a fetch is outstanding
        do_reset();
        post_reset();
        drive(0, 0, 0, 32'd0);
        do_reset();
        post_reset();
        to_hold();
        drive(0, 1, 0, 32'd0);

        // Memory that never acks
        do_reset();
        post_reset();
        n = 0;
        while (imem_req && n < 100) begin
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            n++;
        end
        chk("wait_cycles", n, MAX_WAIT);
        chk("fault_set", fetch_fault, 1);
        chk("fault_req", imem_req, 0);
        chk("fault_valid", instr_valid, 0);
        repeat (5) drive(1, 1, 1, $urandom);
        chk("fault_sticky", fetch_fault, 1);
        chk("fault_req_held", imem_req, 0);
        chk("fault_valid_held", instr_valid, 0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
